// File: rtl/key_debounce_mode.sv
// key_debounce_mode
// Conditions the raw active-low push-button for the VGA paint stage.
// The raw key passes through a two-flop synchroniser, then a stable-interval
// debounce FSM. The module produces a debounced level, one-cycle press and
// release strobes, and a wrap-around mode index that advances once per
// accepted press. All outputs are registered.
module key_debounce_mode #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_MODES       = 5,
  parameter int MODE_W          = 3
) (
  input  logic              Clk_50MHz,
  input  logic              Rst_n,
  input  logic              Key,
  output logic              Key_Pressed,
  output logic              Press_Pulse,
  output logic              Release_Pulse,
  output logic [MODE_W-1:0] Mode
);

  // One extra bit over clog2 gives headroom. The counter never reaches
  // DEBOUNCE_CYCLES, because every state exit clears it.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_ZERO = '0;
  localparam logic [MODE_W-1:0] MODE_ONE  = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  // Synchroniser chain. Both flops reset to the released level (1).
  logic r_k1;
  logic r_ks;

  // FSM and output registers.
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_key_pressed;
  logic              r_press_pulse;
  logic              r_release_pulse;
  logic [MODE_W-1:0] r_mode;

  // Next-state values produced by the combinational process.
  state_t            w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_key_pressed_next;
  logic              w_press_pulse_next;
  logic              w_release_pulse_next;
  logic [MODE_W-1:0] w_mode_next;

  // Helper terms.
  logic              w_cnt_last;
  logic              w_key_low;
  logic [MODE_W-1:0] w_mode_inc;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_key_low  = ~r_ks;
  assign w_mode_inc = (r_mode == MODE_LAST) ? MODE_ZERO : (r_mode + MODE_ONE);

  // Two-flop synchroniser. The raw Key is asynchronous to Clk_50MHz.
  always_ff @(posedge Clk_50MHz) begin
    if (!Rst_n) begin
      r_k1 <= 1'b1;
      r_ks <= 1'b1;
    end else begin
      r_k1 <= Key;
      r_ks <= r_k1;
    end
  end

  // Debounce FSM: next state, counter and registered outputs.
  always_comb begin
    w_state_next         = r_state;
    w_cnt_next           = r_cnt;
    w_key_pressed_next   = r_key_pressed;
    w_press_pulse_next   = 1'b0;
    w_release_pulse_next = 1'b0;
    w_mode_next          = r_mode;

    unique case (r_state)
      IDLE: begin
        if (w_key_low) begin
          w_state_next = PRESS_CHK;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next   = CNT_ZERO;
        end
      end

      PRESS_CHK: begin
        if (!w_key_low) begin
          // A bounce shorter than the interval: drop it silently.
          w_state_next = IDLE;
          w_cnt_next   = CNT_ZERO;
        end else if (w_cnt_last) begin
          w_state_next       = HELD;
          w_cnt_next         = CNT_ZERO;
          w_press_pulse_next = 1'b1;
          w_key_pressed_next = 1'b1;
          w_mode_next        = w_mode_inc;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      HELD: begin
        // Holding the key forever stays here. No repeat pulses.
        if (!w_key_low) begin
          w_state_next = RELEASE_CHK;
          w_cnt_next   = CNT_ONE;
        end
      end

      RELEASE_CHK: begin
        if (w_key_low) begin
          // A short release glitch: the key is still considered held.
          w_state_next = HELD;
          w_cnt_next   = CNT_ZERO;
        end else if (w_cnt_last) begin
          w_state_next         = IDLE;
          w_cnt_next           = CNT_ZERO;
          w_release_pulse_next = 1'b1;
          w_key_pressed_next   = 1'b0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers. Reset abandons any check in progress.
  always_ff @(posedge Clk_50MHz) begin
    if (!Rst_n) begin
      r_state         <= IDLE;
      r_cnt           <= CNT_ZERO;
      r_key_pressed   <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_mode          <= MODE_ZERO;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_key_pressed   <= w_key_pressed_next;
      r_press_pulse   <= w_press_pulse_next;
      r_release_pulse <= w_release_pulse_next;
      r_mode          <= w_mode_next;
    end
  end

  assign Key_Pressed   = r_key_pressed;
  assign Press_Pulse   = r_press_pulse;
  assign Release_Pulse = r_release_pulse;
  assign Mode          = r_mode;

endmodule

// File: tb/tb_key_debounce_mode.sv
// Testbench for key_debounce_mode.
// The table rows are low/high run lengths for the key. When a run is driven,
// the bench predicts the press/release strobes (cycle number and Mode) and
// queues them. Each clock tick pops and compares every strobe the DUT emits.
module tb_key_debounce_mode;

  localparam int N      = 8;
  localparam int NMODES = 5;
  localparam int MW     = 3;
  localparam int LAT    = N + 2;

  logic          clk;
  logic          rst_n;
  logic          key;
  logic          key_pressed;
  logic          press_pulse;
  logic          release_pulse;
  logic [MW-1:0] mode;

  key_debounce_mode #(
    .DEBOUNCE_CYCLES(N),
    .NUM_MODES      (NMODES),
    .MODE_W         (MW)
  ) dut (
    .Clk_50MHz    (clk),
    .Rst_n        (rst_n),
    .Key          (key),
    .Key_Pressed  (key_pressed),
    .Press_Pulse  (press_pulse),
    .Release_Pulse(release_pulse),
    .Mode         (mode)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    bit            rel;
    int            cyc;
    logic [MW-1:0] md;
  } exp_t;

  typedef struct {
    int low_len;
    int high_len;
  } vec_t;

  exp_t          q[$];
  int            checks;
  int            errors;
  int            cyc;
  bit            m_pressed;
  logic [MW-1:0] m_mode;
  vec_t          vecs[14];

  function automatic logic [MW-1:0] next_mode(input logic [MW-1:0] m);
    return (m == MW'(NMODES - 1)) ? '0 : m + MW'(1);
  endfunction

  task automatic check_pulse(input bit rel);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s at cycle %0d: got a strobe with mode=%0d, expected no strobe",
               rel ? "release" : "press", cyc, mode);
    end else begin
      e = q.pop_front();
      if (e.rel != rel || e.cyc != cyc || e.md != mode) begin
        errors++;
        $display("FAIL pulse_%s: got rel=%0b cycle=%0d mode=%0d, expected rel=%0b cycle=%0d mode=%0d",
                 rel ? "release" : "press", rel, cyc, mode, e.rel, e.cyc, e.md);
      end
    end
  endtask

  // Advance one clock, sample after the edge, and score any strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (press_pulse && release_pulse) begin
      checks++;
      errors++;
      $display("FAIL both_pulses at cycle %0d: got press=1 release=1, expected at most one", cyc);
    end
    if (press_pulse)   check_pulse(1'b0);
    if (release_pulse) check_pulse(1'b1);
  endtask

  // Drive the key at level v for n edges. The strobe is predicted up front.
  task automatic hold(input bit v, input int n);
    exp_t e;
    key = v;
    if (!v && !m_pressed && n >= N) begin
      m_mode    = next_mode(m_mode);
      m_pressed = 1'b1;
      e.rel = 1'b0; e.cyc = cyc + LAT; e.md = m_mode;
      q.push_back(e);
    end else if (v && m_pressed && n >= N) begin
      m_pressed = 1'b0;
      e.rel = 1'b1; e.cyc = cyc + LAT; e.md = m_mode;
      q.push_back(e);
    end
    for (int i = 0; i < n; i++) tick();
    // Skip the level check while a strobe may still be in flight.
    if (n < N || n >= N + 4) begin
      checks++;
      if (key_pressed != m_pressed) begin
        errors++;
        $display("FAIL key_pressed_level at cycle %0d: got %0b, expected %0b",
                 cyc, key_pressed, m_pressed);
      end
    end
  endtask

  // Hold reset for n cycles with the key at level kv, then release reset.
  task automatic do_reset(input int n, input bit kv);
    exp_t e;
    rst_n = 1'b0;
    key   = kv;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (key_pressed !== 1'b0 || press_pulse !== 1'b0 ||
          release_pulse !== 1'b0 || mode !== '0) begin
        errors++;
        $display("FAIL reset_state at cycle %0d: got kp=%0b pp=%0b rp=%0b mode=%0d, expected all 0",
                 cyc, key_pressed, press_pulse, release_pulse, mode);
      end
    end
    m_mode    = '0;
    m_pressed = 1'b0;
    rst_n     = 1'b1;
    // A key still held low through reset release counts as a brand-new press.
    if (!kv) begin
      m_mode    = next_mode(m_mode);
      m_pressed = 1'b1;
      e.rel = 1'b0; e.cyc = cyc + LAT; e.md = m_mode;
      q.push_back(e);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    m_pressed = 1'b0;
    m_mode    = '0;
    rst_n     = 1'b0;
    key       = 1'b0;

    vecs[0]  = '{30, 30};  // clean press/release
    vecs[1]  = '{5,  2};   // bounce: too short
    vecs[2]  = '{20, 20};  // press after bounce
    vecs[3]  = '{7,  12};  // one short of the interval: no press
    vecs[4]  = '{8,  8};   // exactly the interval both ways
    vecs[5]  = '{12, 12};
    vecs[6]  = '{20, 3};   // release glitch while held
    vecs[7]  = '{15, 15};  // still held, then real release
    vecs[8]  = '{12, 12};
    vecs[9]  = '{12, 12};
    vecs[10] = '{12, 12};
    vecs[11] = '{12, 12};
    vecs[12] = '{12, 12};
    vecs[13] = '{12, 12};

    // Reset with the key held low. A press follows after the full interval.
    do_reset(4, 1'b0);
    hold(1'b0, 12);
    hold(1'b1, 15);

    // Table-driven runs.
    for (int i = 0; i < 14; i++) begin
      hold(1'b0, vecs[i].low_len);
      hold(1'b1, vecs[i].high_len);
    end

    // Reset in the middle of a press check: the check is abandoned.
    hold(1'b0, 7);
    do_reset(3, 1'b0);
    hold(1'b0, 12);
    hold(1'b1, 15);

    // Mode wrap from a fresh reset: expect 1,2,3,4,0,1.
    do_reset(2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      hold(1'b0, 12);
      hold(1'b1, 12);
    end

    // Drain the pipeline, then confirm nothing predicted was missed.
    hold(1'b1, 20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d strobes still pending, expected 0", q.size());
    end
    checks++;
    if (mode != m_mode) begin
      errors++;
      $display("FAIL final_mode: got %0d, expected %0d", mode, m_mode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
